// File: rtl/sr_cmd_pkg.sv
// Shared constants for the SR command generator: resolver priority codes,
// default debounce length and the debounce counter width helper.
package sr_cmd_pkg;
  localparam int PRIO_NONE        = 0;
  localparam int PRIO_SET         = 1;
  localparam int PRIO_RESET       = 2;
  localparam int DEBOUNCE_DEFAULT = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and command/level outputs of the SR command generator.
interface sr_cmd_gen_if;
  logic btn_s;
  logic btn_r;
  logic s;
  logic r;
  logic conflict;
  logic s_level;
  logic r_level;

  modport master (output btn_s, btn_r, input s, r, conflict, s_level, r_level);
  modport slave  (input btn_s, btn_r, output s, r, conflict, s_level, r_level);
endinterface

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced level
// and a look-ahead rise flag that is high in the cycle before level goes 0->1.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Counter never exceeds LAST: it either clears or flips the level there.
  assign flip = (sync2 != level) && (cnt == LAST);
  assign rise = flip & sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (flip) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced, edge-detected set/reset command pulses with a registered
// conflict resolver that never lets s and r be high together.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int PRIORITY        = PRIO_NONE
) (
  input logic         clk,
  input logic         rst,
  sr_cmd_gen_if.slave bus
);
  logic rise_s;
  logic rise_r;
  logic s_lvl;
  logic r_lvl;
  logic s_nxt;
  logic r_nxt;
  logic s_q;
  logic r_q;
  logic conflict_q;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
    .clk(clk), .rst(rst), .din(bus.btn_s), .level(s_lvl), .rise(rise_s)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk(clk), .rst(rst), .din(bus.btn_r), .level(r_lvl), .rise(rise_r)
  );

  always_comb begin
    s_nxt = rise_s & ~rise_r;
    r_nxt = rise_r & ~rise_s;
    if (rise_s && rise_r) begin
      s_nxt = (PRIORITY == PRIO_SET);
      r_nxt = (PRIORITY == PRIO_RESET);
    end
  end

  // Registered on the same edge that the debounced levels rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_nxt;
      r_q        <= r_nxt;
      conflict_q <= rise_s & rise_r;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.conflict = conflict_q;
  assign bus.s_level  = s_lvl;
  assign bus.r_level  = r_lvl;
endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: five instances covering D=4 with all three
// priorities, plus D=1 and D=8, all driven from the same two buttons.
module tb_sr_cmd_gen;
  import sr_cmd_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic btn_s = 1'b0;
  logic btn_r = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   hs [0:2099];
  bit   hr [0:2099];

  always #5 clk = ~clk;

  sr_cmd_gen_if bus0 ();
  sr_cmd_gen_if bus1 ();
  sr_cmd_gen_if bus2 ();
  sr_cmd_gen_if bus3 ();
  sr_cmd_gen_if bus4 ();

  assign bus0.btn_s = btn_s;  assign bus0.btn_r = btn_r;
  assign bus1.btn_s = btn_s;  assign bus1.btn_r = btn_r;
  assign bus2.btn_s = btn_s;  assign bus2.btn_r = btn_r;
  assign bus3.btn_s = btn_s;  assign bus3.btn_r = btn_r;
  assign bus4.btn_s = btn_s;  assign bus4.btn_r = btn_r;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PRIORITY(PRIO_NONE))  u0 (.clk(clk), .rst(rst), .bus(bus0));
  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PRIORITY(PRIO_SET))   u1 (.clk(clk), .rst(rst), .bus(bus1));
  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PRIORITY(PRIO_RESET)) u2 (.clk(clk), .rst(rst), .bus(bus2));
  sr_cmd_gen #(.DEBOUNCE_CYCLES(1), .PRIORITY(PRIO_NONE))  u3 (.clk(clk), .rst(rst), .bus(bus3));
  sr_cmd_gen #(.DEBOUNCE_CYCLES(8), .PRIORITY(PRIO_NONE))  u4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    btn_s = 1'b0;
    btn_r = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    rst   = 1'b0;
    btn_s = 1'b1;
    btn_r = 1'b1;
    repeat (3) tick();
    outs = {bus0.s, bus0.r, bus0.conflict, bus0.s_level, bus0.r_level};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000", outs);
    end
    rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks += 5;
      if (bus0.conflict !== (n == 6)) begin
        errors++; $display("FAIL rel_conflict n=%0d got %b want %b", n, bus0.conflict, n == 6);
      end
      if ({bus0.s, bus0.r} !== 2'b00) begin
        errors++; $display("FAIL rel_sr n=%0d got %b want 00", n, {bus0.s, bus0.r});
      end
      if (bus0.s_level !== (n >= 6)) begin
        errors++; $display("FAIL rel_slevel n=%0d got %b want %b", n, bus0.s_level, n >= 6);
      end
      if (bus3.conflict !== (n == 3)) begin
        errors++; $display("FAIL rel_conflict_d1 n=%0d got %b want %b", n, bus3.conflict, n == 3);
      end
      if (bus1.s !== (n == 6)) begin
        errors++; $display("FAIL rel_s_p1 n=%0d got %b want %b", n, bus1.s, n == 6);
      end
    end
    idle();
  endtask

  task automatic test_single_press();
    btn_s = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks += 5;
      if (bus0.s !== (n == 6)) begin
        errors++; $display("FAIL press_s n=%0d got %b want %b", n, bus0.s, n == 6);
      end
      if (bus0.s_level !== (n >= 6)) begin
        errors++; $display("FAIL press_slevel n=%0d got %b want %b", n, bus0.s_level, n >= 6);
      end
      if (bus0.r !== 1'b0) begin
        errors++; $display("FAIL press_r n=%0d got %b want 0", n, bus0.r);
      end
      if (bus4.s !== (n == 10)) begin
        errors++; $display("FAIL press_s_d8 n=%0d got %b want %b", n, bus4.s, n == 10);
      end
      if (bus3.s !== (n == 3)) begin
        errors++; $display("FAIL press_s_d1 n=%0d got %b want %b", n, bus3.s, n == 3);
      end
    end
    idle();
    checks++;
    if (bus0.s_level !== 1'b0) begin
      errors++; $display("FAIL release_slevel got %b want 0", bus0.s_level);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btn_s = (i % 2 == 0);
      tick();
      checks += 2;
      if (bus0.s !== 1'b0) begin
        errors++; $display("FAIL bounce_s i=%0d got %b want 0", i, bus0.s);
      end
      if (bus0.s_level !== 1'b0) begin
        errors++; $display("FAIL bounce_slevel i=%0d got %b want 0", i, bus0.s_level);
      end
    end
    btn_s = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (bus0.s !== (n == 6)) begin
        errors++; $display("FAIL settle_s n=%0d got %b want %b", n, bus0.s, n == 6);
      end
    end
    idle();
  endtask

  task automatic test_conflict();
    btn_s = 1'b1;
    btn_r = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks += 3;
      if ({bus0.s, bus0.r, bus0.conflict} !== {2'b00, n == 6}) begin
        errors++; $display("FAIL conf_p0 n=%0d got %b want %b", n,
                           {bus0.s, bus0.r, bus0.conflict}, {2'b00, n == 6});
      end
      if ({bus1.s, bus1.r, bus1.conflict} !== {n == 6, 1'b0, n == 6}) begin
        errors++; $display("FAIL conf_p1 n=%0d got %b want %b", n,
                           {bus1.s, bus1.r, bus1.conflict}, {n == 6, 1'b0, n == 6});
      end
      if ({bus2.s, bus2.r, bus2.conflict} !== {1'b0, n == 6, n == 6}) begin
        errors++; $display("FAIL conf_p2 n=%0d got %b want %b", n,
                           {bus2.s, bus2.r, bus2.conflict}, {1'b0, n == 6, n == 6});
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [4:0] outs;
    btn_r = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks += 2;
      if (bus0.r !== (n == 6)) begin
        errors++; $display("FAIL mid_r n=%0d got %b want %b", n, bus0.r, n == 6);
      end
      if (bus0.s !== 1'b0) begin
        errors++; $display("FAIL mid_s n=%0d got %b want 0", n, bus0.s);
      end
    end
    btn_s = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus0.r_level !== 1'b1) begin
      errors++; $display("FAIL mid_rlevel got %b want 1", bus0.r_level);
    end
    #2;
    rst   = 1'b0;
    btn_r = 1'b0;
    #1;
    outs = {bus0.s, bus0.r, bus0.conflict, bus0.s_level, bus0.r_level};
    checks++;
    if (outs !== 5'b0) begin
      errors++; $display("FAIL async_reset got %b want 00000", outs);
    end
    repeat (2) tick();
    rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks += 2;
      if (bus0.s !== (n == 6)) begin
        errors++; $display("FAIL after_rst_s n=%0d got %b want %b", n, bus0.s, n == 6);
      end
      if ({bus0.r, bus0.conflict} !== 2'b00) begin
        errors++; $display("FAIL after_rst_r n=%0d got %b want 00", n, {bus0.r, bus0.conflict});
      end
    end
    idle();
  endtask

  task automatic test_random();
    int  run_s  = 0;
    int  run_r  = 0;
    int  pulses = 0;
    int  d;
    bit  ok;
    logic ps, pr;
    for (int n = 0; n < 2100; n++) begin
      if (n < 30) begin
        btn_s = 1'b0;
        btn_r = 1'b0;
      end else begin
        if (run_s == 0) begin
          btn_s = 1'($urandom_range(0, 1));
          run_s = $urandom_range(1, 12);
        end
        if (run_r == 0) begin
          btn_r = 1'($urandom_range(0, 1));
          run_r = $urandom_range(1, 12);
        end
        run_s--;
        run_r--;
      end
      hs[n] = btn_s;
      hr[n] = btn_r;
      tick();
      checks += 3;
      if ((bus0.s & bus0.r) !== 1'b0) begin
        errors++; $display("FAIL rand_excl_d4 n=%0d got s=%b r=%b", n, bus0.s, bus0.r);
      end
      if ((bus3.s & bus3.r) !== 1'b0) begin
        errors++; $display("FAIL rand_excl_d1 n=%0d got s=%b r=%b", n, bus3.s, bus3.r);
      end
      if ((bus4.s & bus4.r) !== 1'b0) begin
        errors++; $display("FAIL rand_excl_d8 n=%0d got s=%b r=%b", n, bus4.s, bus4.r);
      end
      for (int k = 0; k < 2; k++) begin
        d  = (k == 0) ? 1 : 8;
        ps = (k == 0) ? bus3.s : bus4.s;
        pr = (k == 0) ? bus3.r : bus4.r;
        if (ps === 1'b1) begin
          pulses++;
          ok = 1'b1;
          for (int j = n - d - 1; j <= n - 2; j++) ok &= hs[j];
          checks++;
          if (!ok) begin
            errors++; $display("FAIL rand_stable_s d=%0d n=%0d got unstable want %0d-cycle high", d, n, d);
          end
        end
        if (pr === 1'b1) begin
          pulses++;
          ok = 1'b1;
          for (int j = n - d - 1; j <= n - 2; j++) ok &= hr[j];
          checks++;
          if (!ok) begin
            errors++; $display("FAIL rand_stable_r d=%0d n=%0d got unstable want %0d-cycle high", d, n, d);
          end
        end
      end
    end
    checks++;
    if (pulses == 0) begin
      errors++; $display("FAIL rand_pulses got 0 want >0");
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
